// File: rtl/fetch_pkg.sv
// Shared constants and entry type for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             wdata,
    input  logic                     pop,
    output fetch_entry_t             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          do_push;
    logic          do_pop;

    assign count   = wptr - rptr;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (wptr == rptr);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited imem requests, prefetch FIFO,
// redirect with stale-response discard, and the IF/ID pipeline register.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o
);

    localparam int unsigned   CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CREDITS = CW'(DEPTH);

    logic [31:0]   fpc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic          grant;
    logic          push;
    logic          pop;
    fetch_entry_t  pcq_entry;
    fetch_entry_t  pcq_head;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] pcq_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pcq_full;
    logic          pcq_empty;
    logic          unused_ok;

    // Buffered plus in-flight words never exceed DEPTH, so a push always finds room.
    assign imem_req_o  = !rst_i && !redirect_i && ((outstanding + fifo_count) < CREDITS);
    assign imem_addr_o = fpc;
    assign grant       = imem_req_o && imem_gnt_i;
    assign push        = imem_rvalid_i && (drop_cnt == '0) && !redirect_i;
    assign pop         = !redirect_i && !stall_i && !flush_i && !fifo_empty;
    assign pcq_entry   = '{pc: fpc, instr: NOP_INSTR};
    assign push_entry  = '{pc: pcq_head.pc, instr: imem_rdata_i};
    assign unused_ok   = ^{redirect_pc_i[1:0], pcq_head.instr, pcq_count,
                           pcq_full, pcq_empty, fifo_full};

    fetch_fifo #(.DEPTH(DEPTH)) u_pcq (
        .clk   (clk_i),
        .rst   (rst_i),
        .flush (redirect_i),
        .push  (grant),
        .wdata (pcq_entry),
        .pop   (push),
        .rdata (pcq_head),
        .count (pcq_count),
        .full  (pcq_full),
        .empty (pcq_empty)
    );

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .flush (redirect_i),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fpc         <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            case ({grant, imem_rvalid_i})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: ;
            endcase
            if (redirect_i) begin
                fpc      <= {redirect_pc_i[31:2], 2'b00};
                // Everything still in flight after this cycle's response is stale.
                drop_cnt <= outstanding - CW'(imem_rvalid_i);
            end else begin
                if (grant) fpc <= fpc + PC_STEP;
                if (imem_rvalid_i && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || redirect_i) begin
            instr_o <= NOP_INSTR;
            pc_o    <= '0;
            valid_o <= 1'b0;
        end else if (!stall_i) begin
            if (pop) begin
                instr_o <= head.instr;
                pc_o    <= head.pc;
                valid_o <= 1'b1;
            end else begin
                instr_o <= NOP_INSTR;
                pc_o    <= '0;
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: in-order memory model returning word = address,
// with hand-traced IF/ID sequences for run, stall, flush, grant stall, redirect and reset.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        req;
    logic [31:0] addr;
    logic        gnt = 1'b1;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } rsp_t;

    rsp_t q[$];
    int   cyc = 0;
    int   lat = 1;
    int   n_vec = 0;
    int   n_miss = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .flush_i       (flush),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_gnt_i    (gnt),
        .imem_rvalid_i (rvalid),
        .imem_rdata_i  (rdata),
        .instr_o       (instr),
        .pc_o          (pc),
        .valid_o       (valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_if(input string tag, input logic v, input logic [31:0] exp_pc);
        check_eq({tag, "_valid"}, valid, v);
        if (v) begin
            check_eq({tag, "_pc"}, pc, exp_pc);
            check_eq({tag, "_instr"}, instr, exp_pc);
        end else begin
            check_eq({tag, "_nop"}, instr, NOP_INSTR);
        end
    endtask

    // Capture this cycle's grant, advance one clock, then present any due response.
    task automatic tick();
        if (req && gnt) q.push_back('{cyc + lat, addr});
        @(posedge clk);
        #1;
        cyc++;
        rvalid = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            rvalid = 1'b1;
            rdata  = q[0].addr;
            void'(q.pop_front());
        end
    endtask

    task automatic do_reset(input int l);
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
        redirect_pc = '0; gnt = 1'b1;
        repeat (2) begin
            #1;
            tick();
        end
        #1;
        check_eq("rst_req", req, 1'b0);
        check_eq("rst_valid", valid, 1'b0);
        check_eq("rst_instr", instr, NOP_INSTR);
        check_eq("rst_pc", pc, 32'h0);
        q.delete();
        rvalid = 1'b0;
        rdata  = '0;
        lat    = l;
        rst    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Free run, 1-cycle latency
        do_reset(1);
        #1;
        check_eq("t1_req0", req, 1'b1);
        check_eq("t1_addr0", addr, 32'h0);
        tick();
        for (int n = 1; n <= 2; n++) begin
            #1; check_if("t1_bubble", 1'b0, 32'h0); tick();
        end
        for (int n = 3; n <= 10; n++) begin
            #1; check_if("t1_run", 1'b1, 32'(4 * (n - 3))); tick();
        end

        // Stall for cycles 3..5: credit limit stops requests, then resume without gaps
        do_reset(1);
        for (int n = 0; n <= 2; n++) begin
            #1; tick();
        end
        stall = 1'b1;
        #1; check_if("t2_s3", 1'b1, 32'h0); tick();
        #1; check_eq("t2_req4", req, 1'b1); check_eq("t2_addr4", addr, 32'd16);
        check_if("t2_s4", 1'b1, 32'h0); tick();
        #1; check_eq("t2_req5", req, 1'b0); check_if("t2_s5", 1'b1, 32'h0); tick();
        stall = 1'b0;
        #1; check_eq("t2_req6", req, 1'b0); check_if("t2_s6", 1'b1, 32'h0); tick();
        for (int n = 7; n <= 14; n++) begin
            #1; check_if("t2_run", 1'b1, 32'(4 * (n - 6))); tick();
        end

        // One-cycle flush: bubble, then the buffered word follows
        do_reset(1);
        for (int n = 0; n <= 3; n++) begin
            #1; tick();
        end
        flush = 1'b1;
        #1; check_if("t3_f4", 1'b1, 32'd4); tick();
        flush = 1'b0;
        #1; check_if("t3_f5", 1'b0, 32'h0); tick();
        for (int n = 6; n <= 10; n++) begin
            #1; check_if("t3_run", 1'b1, 32'(4 * (n - 4))); tick();
        end

        // Grant withheld for cycles 3..7
        do_reset(1);
        for (int n = 0; n <= 2; n++) begin
            #1; tick();
        end
        gnt = 1'b0;
        for (int n = 3; n <= 7; n++) begin
            #1;
            check_eq("t4_req", req, 1'b1);
            check_eq("t4_addr", addr, 32'd12);
            if (n <= 5) check_if("t4_drain", 1'b1, 32'(4 * (n - 3)));
            else        check_if("t4_bubble", 1'b0, 32'h0);
            tick();
        end
        gnt = 1'b1;
        #1; check_eq("t4_addr8", addr, 32'd12); check_if("t4_b8", 1'b0, 32'h0); tick();
        #1; check_eq("t4_addr9", addr, 32'd16); check_if("t4_b9", 1'b0, 32'h0); tick();
        #1; check_if("t4_b10", 1'b0, 32'h0); tick();
        for (int n = 11; n <= 13; n++) begin
            #1; check_if("t4_run", 1'b1, 32'(12 + 4 * (n - 11))); tick();
        end

        // Redirect with two responses in flight (2-cycle latency)
        do_reset(2);
        for (int n = 0; n <= 3; n++) begin
            #1; tick();
        end
        #1; check_if("t5_c4", 1'b1, 32'd0); tick();
        #1; check_if("t5_c5", 1'b1, 32'd4); tick();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1; check_eq("t5_req6", req, 1'b0); check_if("t5_c6", 1'b1, 32'd8); tick();
        redirect = 1'b0;
        redirect_pc = '0;
        #1; check_eq("t5_req7", req, 1'b1); check_eq("t5_addr7", addr, 32'h0000_0100);
        check_if("t5_c7", 1'b0, 32'h0); tick();
        #1; check_eq("t5_addr8", addr, 32'h0000_0104); check_if("t5_c8", 1'b0, 32'h0); tick();
        for (int n = 9; n <= 10; n++) begin
            #1; check_if("t5_gap", 1'b0, 32'h0); tick();
        end
        for (int n = 11; n <= 13; n++) begin
            #1; check_if("t5_run", 1'b1, 32'(32'h100 + 4 * (n - 11))); tick();
        end

        // Reset pulse with the FIFO full
        do_reset(1);
        for (int n = 0; n <= 2; n++) begin
            #1; tick();
        end
        stall = 1'b1;
        for (int n = 3; n <= 6; n++) begin
            #1;
            if (n >= 5) check_eq("t6_req_full", req, 1'b0);
            tick();
        end
        #1; check_if("t6_c6", 1'b1, 32'h0);
        rst = 1'b1;
        #1; check_eq("t6_req_rst", req, 1'b0); tick();
        rst = 1'b0;
        stall = 1'b0;
        #1;
        check_eq("t6_valid", valid, 1'b0);
        check_eq("t6_instr", instr, NOP_INSTR);
        check_eq("t6_pc", pc, 32'h0);
        check_eq("t6_req", req, 1'b1);
        check_eq("t6_addr", addr, 32'h0);
        tick();
        for (int n = 1; n <= 2; n++) begin
            #1; check_if("t6_bubble", 1'b0, 32'h0); tick();
        end
        for (int n = 3; n <= 5; n++) begin
            #1; check_if("t6_run", 1'b1, 32'(4 * (n - 3))); tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
